display_fifo_reader: RTL and testbench
======================================

Name: display_fifo_reader

Overview:
- Read-side engine for the 48-bit display DMA FIFO.
- Prefetches 48-bit words (two packed 24-bit RGB pixels) from the FIFO into a small local word buffer.
- Unpacks them and delivers exactly one pixel per clock whenever the display timing generator asserts data-enable.
- Handles FIFO underflow with a fill colour and sticky status, and resynchronises on every frame start.

Parameters:
- BUF_DEPTH, 4: local word buffer entries; power of 2, >= RD_LATENCY+2.
- RD_LATENCY, 2: cycles from fifo_rd_en_o high to matching fifo_rd_valid_i high.
- UNDERFLOW_COLOR, 24'h000000: pixel driven when a pixel is needed but none is buffered.
- CNT_WIDTH, 16: width of the underflow counter.

Ports:
- clk_i  in  1  single system/pixel clock; all logic on rising edge.
- a_rstn_i  in  1  asynchronous, active-low reset.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_en_o  out  1  FIFO read request.
- fifo_rd_valid_i  in  1  FIFO read data valid.
- fifo_rdata_i  in  48  FIFO read data; [23:0] is pixel 0 (first displayed), [47:24] is pixel 1.
- frame_start_i  in  1  one-cycle pulse at the start of each frame (before the first de_i).
- de_i  in  1  display data-enable from the timing generator.
- status_clr_i  in  1  synchronous clear of underflow status.
- pixel_o  out  24  output RGB pixel.
- pixel_de_o  out  1  de_i delayed by one cycle, aligned with pixel_o.
- underflow_o  out  1  sticky flag: a pixel was needed but none was available.
- underflow_cnt_o  out  CNT_WIDTH  number of underflowed pixels; saturating.

Behaviour:
- Reset values (a_rstn_i low, asynchronous):
  - all outputs 0;
  - buffer empty, half-select = 0, outstanding = 0, discard = 0.
- Read issue (combinational output):
  - fifo_rd_en_o = !fifo_empty_i && (buf_count + outstanding) < BUF_DEPTH && !frame_start_i.
  - This credit rule guarantees every returned word has a slot; the buffer never overflows.
- Outstanding counter:
  - +1 on each cycle fifo_rd_en_o is high;
  - -1 on each cycle fifo_rd_valid_i is high;
  - both in the same cycle leaves it unchanged;
  - width is clog2(BUF_DEPTH)+1.
- Word accept:
  - On fifo_rd_valid_i, if discard == 0, write fifo_rdata_i to the buffer tail and increment buf_count.
  - Otherwise drop the word and decrement discard.
- Pixel delivery on each de_i cycle:
  - If buf_count > 0:
    - pixel_o <= head[23:0] when half-select = 0, else head[47:24];
    - toggle half-select;
    - when half-select was 1, pop the head word.
  - If buf_count == 0:
    - pixel_o <= UNDERFLOW_COLOR;
    - underflow_o <= 1;
    - underflow_cnt_o increments, saturating at all-ones;
    - half-select is unchanged.
- Latency: pixel_o and pixel_de_o are registered, one cycle after de_i. When de_i is low, pixel_o holds its previous value.
- Simultaneous push and pop in one cycle: buf_count is unchanged and the read/write pointers both advance; this must hold when the buffer is full.
- Frame start (frame_start_i high), applied regardless of de_i:
  - buffer flushed (buf_count = 0, pointers = 0);
  - half-select = 0;
  - discard <= outstanding, minus 1 if fifo_rd_valid_i is also high that cycle, so in-flight words are dropped;
  - no read issued this cycle;
  - status is not cleared.
- Status:
  - status_clr_i clears underflow_o and underflow_cnt_o next cycle.
  - status_clr_i has priority over a same-cycle underflow increment.
- Reset mid-operation clears everything immediately. The FIFO is expected to be reset with the same reset.
- Pointer wrap: pointers wrap modulo BUF_DEPTH.

Test Plan:
- Steady stream: FIFO preloaded with words 0x000002_000001, 0x000004_000003, ...; 16 de_i cycles -> pixel_o = 1,2,3,...,16 on consecutive cycles, pixel_de_o high 16 cycles, underflow_o stays 0.
- Credit limit: fifo_empty_i held 0, de_i held 0 -> fifo_rd_en_o asserted exactly BUF_DEPTH (4) times, then held low; exactly 4 words buffered, none lost.
- Underflow: buffer holds 1 word 0xBBBBBB_AAAAAA, de_i high 4 cycles, FIFO empty -> pixel_o = AAAAAA, BBBBBB, 000000, 000000; underflow_o = 1; underflow_cnt_o = 2.
- Frame resync: frame_start_i pulsed while 2 reads outstanding and half-select = 1 -> the next 2 rd_valid words are dropped; the following word's [23:0] is the first pixel output.
- Full buffer with simultaneous pop and push for 32 cycles -> continuous in-order pixels, buf_count stays 4, no overflow.
- Counter saturation and clear: CNT_WIDTH=4, 20 underflow pixels -> underflow_cnt_o = 15; status_clr_i pulse in the same cycle as an underflow -> count 0, flag 0 next cycle.

Source files
------------

// File: rtl/display_fifo_reader.sv
// Read-side engine for the 48-bit display DMA FIFO: prefetches packed pixel pairs
// into a small word buffer and delivers one 24-bit pixel per data-enable cycle.
module display_fifo_reader #(
    parameter int          BUF_DEPTH       = 4,
    parameter int          RD_LATENCY      = 2,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 a_rstn_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_en_o,
    input  logic                 fifo_rd_valid_i,
    input  logic [47:0]          fifo_rdata_i,
    input  logic                 frame_start_i,
    input  logic                 de_i,
    input  logic                 status_clr_i,
    output logic [23:0]          pixel_o,
    output logic                 pixel_de_o,
    output logic                 underflow_o,
    output logic [CNT_WIDTH-1:0] underflow_cnt_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    if (BUF_DEPTH < RD_LATENCY + 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_param_check
        $error("display_fifo_reader: BUF_DEPTH must be a power of 2 and >= RD_LATENCY+2");
    end

    logic [47:0]          r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_outstanding;
    logic [CNT_W-1:0]     r_discard;
    logic                 r_half;
    logic [23:0]          r_pixel;
    logic                 r_pixel_de;
    logic                 r_underflow;
    logic [CNT_WIDTH-1:0] r_uf_cnt;

    logic [CNT_W-1:0] w_credit;
    logic             w_rd_en;
    logic             w_accept;
    logic             w_have;
    logic             w_pop;
    logic             w_under;
    logic [47:0]      w_head;

    // Words already buffered plus words in flight may never exceed the buffer,
    // so every returned word is guaranteed a slot.
    assign w_credit = r_count + r_outstanding;
    assign w_rd_en  = !fifo_empty_i && (w_credit < DEPTH_C) && !frame_start_i;
    assign w_accept = fifo_rd_valid_i && (r_discard == '0) && !frame_start_i;
    assign w_have   = (r_count != '0);
    assign w_pop    = de_i && w_have && r_half;
    assign w_under  = de_i && !w_have;
    assign w_head   = r_mem[r_rd_ptr];

    assign fifo_rd_en_o    = w_rd_en;
    assign pixel_o         = r_pixel;
    assign pixel_de_o      = r_pixel_de;
    assign underflow_o     = r_underflow;
    assign underflow_cnt_o = r_uf_cnt;

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= fifo_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge a_rstn_i) begin
        if (!a_rstn_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_half        <= 1'b0;
            r_pixel       <= '0;
            r_pixel_de    <= 1'b0;
            r_underflow   <= 1'b0;
            r_uf_cnt      <= '0;
        end else begin
            r_pixel_de <= de_i;
            if (de_i) begin
                if (w_have) begin
                    r_pixel <= r_half ? w_head[47:24] : w_head[23:0];
                end else begin
                    r_pixel <= UNDERFLOW_COLOR;
                end
            end

            case ({w_rd_en, fifo_rd_valid_i})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (status_clr_i) begin
                r_underflow <= 1'b0;
                r_uf_cnt    <= '0;
            end else if (w_under) begin
                r_underflow <= 1'b1;
                if (r_uf_cnt != '1) begin
                    r_uf_cnt <= r_uf_cnt + CNT_WIDTH'(1);
                end
            end

            // Frame start drops everything buffered and marks in-flight words for discard.
            if (frame_start_i) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_half    <= 1'b0;
                r_discard <= r_outstanding - CNT_W'(fifo_rd_valid_i);
            end else begin
                if (fifo_rd_valid_i && (r_discard != '0)) begin
                    r_discard <= r_discard - CNT_W'(1);
                end
                if (w_accept) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (de_i && w_have) begin
                    r_half <= ~r_half;
                end
                r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_display_fifo_reader.sv
// Randomised and directed bench for display_fifo_reader, checked every cycle
// against a pixel-queue model of the reader plus a latency-2 FIFO model.
module tb_display_fifo_reader;

    localparam int          DEPTH = 4;
    localparam int          CNTW  = 4;
    localparam logic [23:0] UF    = 24'h000000;
    localparam int          CNTMAX = (1 << CNTW) - 1;

    logic            clk_i = 1'b0;
    logic            a_rstn_i;
    logic            fifo_empty_i;
    logic            fifo_rd_en_o;
    logic            fifo_rd_valid_i;
    logic [47:0]     fifo_rdata_i;
    logic            frame_start_i;
    logic            de_i;
    logic            status_clr_i;
    logic [23:0]     pixel_o;
    logic            pixel_de_o;
    logic            underflow_o;
    logic [CNTW-1:0] underflow_cnt_o;

    display_fifo_reader #(
        .BUF_DEPTH(DEPTH),
        .RD_LATENCY(2),
        .UNDERFLOW_COLOR(UF),
        .CNT_WIDTH(CNTW)
    ) dut (
        .clk_i(clk_i),
        .a_rstn_i(a_rstn_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_rd_en_o(fifo_rd_en_o),
        .fifo_rd_valid_i(fifo_rd_valid_i),
        .fifo_rdata_i(fifo_rdata_i),
        .frame_start_i(frame_start_i),
        .de_i(de_i),
        .status_clr_i(status_clr_i),
        .pixel_o(pixel_o),
        .pixel_de_o(pixel_de_o),
        .underflow_o(underflow_o),
        .underflow_cnt_o(underflow_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int nVectors = 0;
    int nMiscompares = 0;
    int rdEnCount = 0;

    // FIFO model state
    logic [47:0] fifoQ[$];
    logic        pipeV = 1'b0;
    logic [47:0] pipeD = '0;
    logic        rdEnSeen;

    // Reader model state
    logic [23:0] pixQ[$];
    int          mInflight = 0;
    int          mDrop = 0;
    logic [23:0] expPix = '0;
    logic        expDe = 1'b0;
    logic        expUf = 1'b0;
    int          expCnt = 0;

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one clock: sample read request mid-cycle, then let the FIFO model respond.
    task automatic tick();
        @(negedge clk_i);
        rdEnSeen = fifo_rd_en_o;
        @(posedge clk_i);
        #1;
        if (a_rstn_i) begin
            fifo_rd_valid_i = pipeV;
            fifo_rdata_i    = pipeD;
            pipeV = rdEnSeen;
            if (rdEnSeen && fifoQ.size() > 0) pipeD = fifoQ.pop_front();
            else pipeD = '0;
            fifo_empty_i = (fifoQ.size() == 0);
        end
    endtask

    task automatic applyStimulus(input logic de, input logic fs, input logic clr);
        de_i = de;
        frame_start_i = fs;
        status_clr_i = clr;
        tick();
        de_i = 1'b0;
        frame_start_i = 1'b0;
        status_clr_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic resetFifoModel();
        fifoQ.delete();
        pipeV = 1'b0;
        pipeD = '0;
        fifo_rd_valid_i = 1'b0;
        fifo_rdata_i = '0;
        fifo_empty_i = 1'b1;
    endtask

    // Compare process: registered outputs against the model's prediction from the
    // previous cycle, read request against the credit rule, then advance the model.
    always @(negedge clk_i) begin
        logic expRdEn;
        logic underNow;
        int   words;
        if (!a_rstn_i) begin
            pixQ.delete();
            mInflight = 0;
            mDrop = 0;
            expPix = '0;
            expDe = 1'b0;
            expUf = 1'b0;
            expCnt = 0;
        end else begin
            checkOutput("pixel_o", pixel_o, expPix);
            checkOutput("pixel_de_o", pixel_de_o, expDe);
            checkOutput("underflow_o", underflow_o, expUf);
            checkOutput("underflow_cnt_o", underflow_cnt_o, expCnt);
            words = (pixQ.size() + 1) / 2;
            expRdEn = !fifo_empty_i && ((words + mInflight) < DEPTH) && !frame_start_i;
            checkOutput("fifo_rd_en_o", fifo_rd_en_o, expRdEn);
            if (fifo_rd_en_o) rdEnCount++;

            underNow = 1'b0;
            if (de_i) begin
                if (pixQ.size() > 0) expPix = pixQ.pop_front();
                else begin
                    expPix = UF;
                    underNow = 1'b1;
                end
            end
            expDe = de_i;
            if (status_clr_i) begin
                expUf = 1'b0;
                expCnt = 0;
            end else if (underNow) begin
                expUf = 1'b1;
                if (expCnt < CNTMAX) expCnt++;
            end
            if (fifo_rd_valid_i) begin
                mInflight--;
                if (mDrop > 0) mDrop--;
                else if (!frame_start_i) begin
                    pixQ.push_back(fifo_rdata_i[23:0]);
                    pixQ.push_back(fifo_rdata_i[47:24]);
                end
            end
            if (expRdEn) mInflight++;
            if (frame_start_i) begin
                pixQ.delete();
                mDrop = mInflight;
            end
        end
    end

    initial begin
        a_rstn_i = 1'b0;
        de_i = 1'b0;
        frame_start_i = 1'b0;
        status_clr_i = 1'b0;
        resetFifoModel();
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_pixel", pixel_o, 24'h0);
        checkOutput("reset_de", pixel_de_o, 1'b0);
        checkOutput("reset_uf", underflow_o, 1'b0);
        checkOutput("reset_cnt", underflow_cnt_o, 0);
        checkOutput("reset_rd_en", fifo_rd_en_o, 1'b0);
        a_rstn_i = 1'b1;

        // Credit limit, then a steady 16-pixel stream
        for (int k = 0; k < 8; k++) fifoQ.push_back({24'(2 * k + 2), 24'(2 * k + 1)});
        rdEnCount = 0;
        idle(10);
        checkOutput("credit_reads", rdEnCount, 4);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("stream_pixel", pixel_o, 24'(i));
            checkOutput("stream_de", pixel_de_o, 1'b1);
        end
        checkOutput("stream_uf", underflow_o, 1'b0);

        // Underflow after a single buffered word
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        fifoQ.push_back(48'hBBBBBB_AAAAAA);
        idle(6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("uf_pix0", pixel_o, 24'hAAAAAA);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("uf_pix1", pixel_o, 24'hBBBBBB);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("uf_pix2", pixel_o, 24'h000000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("uf_pix3", pixel_o, 24'h000000);
        checkOutput("uf_flag", underflow_o, 1'b1);
        checkOutput("uf_cnt", underflow_cnt_o, 2);

        // Frame resync with two reads in flight and half-select set
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        fifoQ.push_back(48'h111112_111111);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resync_w0", pixel_o, 24'h111111);
        fifoQ.push_back(48'h222223_222222);
        fifoQ.push_back(48'h333334_333333);
        fifoQ.push_back(48'h444445_444444);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resync_first", pixel_o, 24'h444444);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resync_second", pixel_o, 24'h444445);

        // Full buffer with continuous push and pop
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 24; k++) fifoQ.push_back({24'(24'h100000 + 2 * k + 1), 24'(24'h100000 + 2 * k)});
        idle(8);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("full_stream", pixel_o, 24'(24'h100000 + i));
        end
        checkOutput("full_uf", underflow_o, 1'b0);

        // Counter saturation and clear priority
        fifoQ.delete();
        fifo_empty_i = 1'b1;
        idle(6);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(4);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sat_cnt", underflow_cnt_o, 15);
        checkOutput("sat_flag", underflow_o, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("clr_cnt", underflow_cnt_o, 0);
        checkOutput("clr_flag", underflow_o, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic de;
            logic fs;
            int pushMod;
            pushMod = (i < 1500) ? 2 : 4;
            if (($urandom % pushMod) == 0 && fifoQ.size() < 12) fifoQ.push_back({$urandom, $urandom} & 48'hFFFFFF_FFFFFF);
            de = ($urandom % 4) != 0;
            fs = (($urandom % 150) == 0) && !de;
            applyStimulus(de, fs, ($urandom % 50) == 0);
        end

        // Asynchronous reset mid-operation
        for (int k = 0; k < 4; k++) fifoQ.push_back({24'h0A0B0C, 24'h0D0E0F});
        idle(6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        #2;
        a_rstn_i = 1'b0;
        #1;
        checkOutput("async_pixel", pixel_o, 24'h0);
        checkOutput("async_de", pixel_de_o, 1'b0);
        checkOutput("async_uf", underflow_o, 1'b0);
        checkOutput("async_cnt", underflow_cnt_o, 0);
        resetFifoModel();
        repeat (2) @(posedge clk_i);
        #1;
        a_rstn_i = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
